game_timer: RTL and testbench

//   Countdown game timer. Sits directly downstream of the access controller: consumes its

---
 rtl/game_timer.sv | 182 ++++++++++++++++++
 tb/tb_game_timer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// Countdown game timer: IDLE -> RUN -> EXPIRED, BCD seconds display, registered outputs.
// Optional 2 Hz low-time blink on warn when GAME_TIMER_WARN_EN is defined.
module game_timer #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter logic [7:0]  GAME_SECONDS = 8'h60,
  parameter logic [7:0]  WARN_SECONDS = 8'h10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       reconfig,
  input  logic [7:0] cfg_seconds,
  output logic       timeout,
  output logic       running,
  output logic       sec_tick,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       warn
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      length_q, length_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            timeout_q, timeout_d;
  logic            running_q, running_d;
  logic            tick_q, tick_d;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    presc_d   = presc_q;
    timeout_d = 1'b0;
    running_d = 1'b0;
    tick_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tens_d  = length_q[7:4];
        ones_d  = length_q[3:0];
        // reconfig wins; a simultaneous enable is picked up next cycle
        if (reconfig) begin
          length_d = {clamp9(cfg_seconds[7:4]), clamp9(cfg_seconds[3:0])};
        end else if (enable) begin
          state_d   = S_RUN;
          running_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
          tens_d  = length_q[7:4];
          ones_d  = length_q[3:0];
          presc_d = '0;
        end else if ({tens_q, ones_q} == 8'h00) begin
          state_d   = S_EXPIRED;
          timeout_d = 1'b1;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end
          if ({tens_d, ones_d} == 8'h00) begin
            state_d   = S_EXPIRED;
            timeout_d = 1'b1;
          end else begin
            running_d = 1'b1;
          end
        end else begin
          presc_d   = presc_q + 1'b1;
          running_d = 1'b1;
        end
      end
      S_EXPIRED: begin
        if (!enable) begin
          state_d = S_IDLE;
          tens_d  = length_q[7:4];
          ones_d  = length_q[3:0];
          presc_d = '0;
        end else begin
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      length_q  <= GAME_SECONDS;
      tens_q    <= GAME_SECONDS[7:4];
      ones_q    <= GAME_SECONDS[3:0];
      presc_q   <= '0;
      timeout_q <= 1'b0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
      running_q <= running_d;
      tick_q    <= tick_d;
    end
  end

  assign timeout   = timeout_q;
  assign running   = running_q;
  assign sec_tick  = tick_q;
  assign secs_tens = tens_q;
  assign secs_ones = ones_q;

`ifdef GAME_TIMER_WARN_EN
  localparam int unsigned BLINK = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int unsigned BW    = (BLINK > 1) ? $clog2(BLINK) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK - 1);

  logic [BW-1:0] blink_q, blink_d;
  logic          warn_q, warn_d;

  // Decided from next-state so warn lines up with the registered digits/state
  always_comb begin
    blink_d = '0;
    warn_d  = 1'b0;
    case (state_d)
      S_EXPIRED: warn_d = 1'b1;
      S_RUN: begin
        if ({tens_d, ones_d} <= WARN_SECONDS) begin
          if (blink_q == BLINK_MAX) begin
            blink_d = '0;
            warn_d  = ~warn_q;
          end else begin
            blink_d = blink_q + 1'b1;
            warn_d  = warn_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_q <= '0;
      warn_q  <= 1'b0;
    end else begin
      blink_q <= blink_d;
      warn_q  <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer (CLK_HZ=10); tick scoreboard checked by an independent monitor.
module tb_game_timer;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       reconfig;
  logic [7:0] cfg_seconds;
  logic       timeout;
  logic       running;
  logic       sec_tick;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       warn;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  game_timer #(.CLK_HZ(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .reconfig   (reconfig),
    .cfg_seconds(cfg_seconds),
    .timeout    (timeout),
    .running    (running),
    .sec_tick   (sec_tick),
    .secs_tens  (secs_tens),
    .secs_ones  (secs_ones),
    .warn       (warn)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int digits();
    return int'({secs_tens, secs_ones});
  endfunction

  // Expected value for a tick, given remaining seconds as a plain integer
  task automatic push_exp(input int s, input logic to);
    exp_t e;
    e.tens = 4'(s / 10);
    e.ones = 4'(s % 10);
    e.to   = to;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset && sec_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: got digits %0h%0h, expected no tick", secs_tens, secs_ones);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({secs_tens, secs_ones, timeout} !== {e.tens, e.ones, e.to}) begin
          errors++;
          $display("FAIL tick: got digits %0h%0h timeout %0b expected digits %0h%0h timeout %0b",
                   secs_tens, secs_ones, timeout, e.tens, e.ones, e.to);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    reconfig    = 1'b0;
    cfg_seconds = 8'h00;
    step(2);
    check("rst_running", int'(running), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_tick", int'(sec_tick), 0);
    check("rst_warn", int'(warn), 0);
    check("rst_digits", digits(), 'h60);
    reset = 1'b0;
    step(1);

    // Default 60 s game, abandoned at 45
    enable = 1'b1;
    step(1);
    check("run_latency", int'(running), 1);
    check("run_digits0", digits(), 'h60);
    for (int s = 59; s >= 45; s--) push_exp(s, 1'b0);
    step(9);
    check("no_early_tick", digits(), 'h60);
    step(1);
    check("first_tick", digits(), 'h59);
    step(140);
    check("at_45", digits(), 'h45);
    enable = 1'b0;
    step(1);
    check("drop_running", int'(running), 0);
    check("drop_reload", digits(), 'h60);
    enable = 1'b1;
    push_exp(59, 1'b0);
    step(10);
    check("presc_cleared", digits(), 'h60);
    step(1);
    check("presc_cleared_tick", digits(), 'h59);
    enable = 1'b0;
    step(1);

    // 3 s game to expiry
    cfg_seconds = 8'h03;
    reconfig    = 1'b1;
    step(1);
    reconfig = 1'b0;
    check("digits_lag", digits(), 'h60);
    step(1);
    check("digits_follow", digits(), 'h03);
    enable = 1'b1;
    push_exp(2, 1'b0);
    push_exp(1, 1'b0);
    push_exp(0, 1'b1);
    step(1);
    check("run3_latency", int'(running), 1);
    step(29);
    check("pre_timeout", int'(timeout), 0);
    check("pre_timeout_digits", digits(), 'h01);
    step(1);
    check("timeout_cycle30", int'(timeout), 1);
    check("expired_running", int'(running), 0);
    check("expired_digits", digits(), 'h00);
    step(5);
    check("timeout_held", int'(timeout), 1);
    check("expired_hold_digits", digits(), 'h00);
    enable = 1'b0;
    step(1);
    check("timeout_clear", int'(timeout), 0);
    check("expired_reload", digits(), 'h03);

    // Zero-length game
    cfg_seconds = 8'h00;
    reconfig    = 1'b1;
    step(1);
    reconfig = 1'b0;
    step(1);
    enable = 1'b1;
    step(1);
    check("zero_running", int'(running), 1);
    check("zero_no_timeout_yet", int'(timeout), 0);
    step(1);
    check("zero_timeout", int'(timeout), 1);
    check("zero_no_tick", int'(sec_tick), 0);
    step(3);
    enable = 1'b0;
    step(1);

    // Borrow across tens digit
    cfg_seconds = 8'h10;
    reconfig    = 1'b1;
    step(1);
    reconfig = 1'b0;
    step(1);
    enable = 1'b1;
    push_exp(9, 1'b0);
    step(11);
    check("borrow", digits(), 'h09);
    enable = 1'b0;
    step(1);

    // Clamp plus reconfig/enable in the same cycle
    cfg_seconds = 8'hAF;
    reconfig    = 1'b1;
    enable      = 1'b1;
    step(1);
    check("reconfig_priority", int'(running), 0);
    reconfig = 1'b0;
    step(1);
    check("clamp_running", int'(running), 1);
    check("clamp_digits", digits(), 'h99);
    push_exp(98, 1'b0);
    step(10);
    check("clamp_tick", digits(), 'h98);

    // Asynchronous reset between clock edges
    step(3);
    #2;
    reset = 1'b1;
    #1;
    check("async_running", int'(running), 0);
    check("async_digits", digits(), 'h60);
    check("async_timeout", int'(timeout), 0);
    enable = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);
    check("post_reset_idle", digits(), 'h60);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
